// File: rtl/spi_readout_sequencer.sv
// spi_readout_sequencer
// Command sequencer sitting behind the SPI slave driver. Every received
// command byte is decoded in the cycle it arrives; the response byte, FSM
// state and all side-band outputs are registered and change on the next edge.
// Handshake: command_valid is a one-cycle strobe with no back-pressure. Every
// strobe is consumed in the cycle it is seen, and the response for it is
// visible on response_byte from the following edge until the next strobe.
module spi_readout_sequencer #(
  parameter int unsigned FRAME_WORDS       = 76800,
  parameter int unsigned WCNT_W            = 17,
  parameter int unsigned DRAIN_BYTES       = 3,
  parameter int unsigned CAPTURE_TIMEOUT   = 2**24,
  parameter logic [7:0]  CMD_NOP           = 8'h00,
  parameter logic [7:0]  CMD_STATUS        = 8'h01,
  parameter logic [7:0]  CMD_CAPTURE       = 8'h02,
  parameter logic [7:0]  CMD_START_READOUT = 8'h03,
  parameter logic [7:0]  CMD_PADDING       = 8'h04,
  parameter logic [7:0]  CMD_STOP_READOUT  = 8'h05,
  parameter logic [7:0]  CMD_RESET         = 8'h06,
  parameter logic [7:0]  RSP_ACK           = 8'hA5,
  parameter logic [7:0]  RSP_NAK           = 8'h5A
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [7:0]        command_byte,
  input  logic              command_valid,
  input  logic              cs_active,
  input  logic              capture_done,
  input  logic              word_tick,
  output logic [7:0]        response_byte,
  output logic              data_transfer,
  output logic              capture_start,
  output logic              transfer_reset,
  output logic [WCNT_W-1:0] words_sent,
  output logic [1:0]        error_flags,
  output logic [2:0]        state_out
);

  // Timeout counter only needs to reach CAPTURE_TIMEOUT-1.
  localparam int unsigned TCNT_W = (CAPTURE_TIMEOUT > 2) ? $clog2(CAPTURE_TIMEOUT) : 1;
  // Drain counter must be able to hold DRAIN_BYTES itself.
  localparam int unsigned DCNT_W = (DRAIN_BYTES > 1) ? $clog2(DRAIN_BYTES + 1) : 1;

  localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(CAPTURE_TIMEOUT - 1);
  localparam logic [DCNT_W-1:0] DRAIN_DONE = DCNT_W'(DRAIN_BYTES);
  localparam logic [WCNT_W-1:0] WORDS_LAST = WCNT_W'(FRAME_WORDS - 1);
  localparam logic [WCNT_W-1:0] WORDS_FULL = WCNT_W'(FRAME_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAPTURING = 3'd1,
    ST_READY     = 3'd2,
    ST_READOUT   = 3'd3,
    ST_DRAIN     = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          rsp_nxt;
  logic [1:0]          flags_nxt;
  logic [WCNT_W-1:0]   words_nxt;
  logic [TCNT_W-1:0]   tcnt, tcnt_nxt;
  logic [DCNT_W-1:0]   dcnt, dcnt_nxt, dcnt_inc;
  logic                cap_start_nxt;
  logic                xfer_rst_nxt;
  logic                data_transfer_nxt;
  logic                cs_prev;
  logic                cs_abort;
  logic                transfer_phase;
  logic                cmd_moves;
  logic                cmd_reset;
  logic [7:0]          status_byte;

  assign state_out      = state;
  assign transfer_phase = (state == ST_READOUT) || (state == ST_DRAIN);
  // Falling edge of the synchronised chip select while the frame is streaming.
  assign cs_abort       = cs_prev && !cs_active && transfer_phase;
  assign status_byte    = {error_flags, 3'b000, state_out};
  assign dcnt_inc       = dcnt + 1'b1;

  // Register every output and internal counter; reset drops data_transfer immediately.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      response_byte  <= 8'h00;
      data_transfer  <= 1'b0;
      capture_start  <= 1'b0;
      transfer_reset <= 1'b0;
      words_sent     <= '0;
      error_flags    <= 2'b00;
      tcnt           <= '0;
      dcnt           <= '0;
      cs_prev        <= 1'b0;
    end else begin
      state          <= state_nxt;
      response_byte  <= rsp_nxt;
      data_transfer  <= data_transfer_nxt;
      capture_start  <= cap_start_nxt;
      transfer_reset <= xfer_rst_nxt;
      words_sent     <= words_nxt;
      error_flags    <= flags_nxt;
      tcnt           <= tcnt_nxt;
      dcnt           <= dcnt_nxt;
      cs_prev        <= cs_active;
    end
  end

  // Next-state logic: command decode first, then the state's own events, then the CS abort override.
  always_comb begin
    state_nxt     = state;
    rsp_nxt       = response_byte;
    flags_nxt     = error_flags;
    words_nxt     = words_sent;
    tcnt_nxt      = tcnt;
    dcnt_nxt      = dcnt;
    cap_start_nxt = 1'b0;
    xfer_rst_nxt  = 1'b0;
    cmd_moves     = 1'b0;
    cmd_reset     = 1'b0;

    if (command_valid) begin
      case (command_byte)
        CMD_NOP: rsp_nxt = 8'h00;
        CMD_STATUS: rsp_nxt = status_byte;
        CMD_CAPTURE: begin
          if (state == ST_IDLE || state == ST_READY) begin
            rsp_nxt       = RSP_ACK;
            state_nxt     = ST_CAPTURING;
            cap_start_nxt = 1'b1;
            tcnt_nxt      = '0;
            flags_nxt[1]  = 1'b0;
            cmd_moves     = 1'b1;
          end else begin
            rsp_nxt = RSP_NAK;
          end
        end
        CMD_START_READOUT: begin
          if (state == ST_READY) begin
            rsp_nxt      = RSP_ACK;
            state_nxt    = ST_READOUT;
            xfer_rst_nxt = 1'b1;
            words_nxt    = '0;
            flags_nxt[0] = 1'b0;
            cmd_moves    = 1'b1;
          end else begin
            rsp_nxt = RSP_NAK;
          end
        end
        CMD_PADDING: begin
          // Padding is always harmless; it only counts while draining.
          rsp_nxt = RSP_ACK;
          if (state == ST_DRAIN) begin
            dcnt_nxt  = dcnt_inc;
            cmd_moves = 1'b1;
            if (dcnt_inc == DRAIN_DONE) begin
              state_nxt = ST_IDLE;
            end
          end
        end
        CMD_STOP_READOUT: begin
          if (transfer_phase) begin
            rsp_nxt   = RSP_ACK;
            state_nxt = ST_IDLE;
            cmd_moves = 1'b1;
          end else begin
            rsp_nxt = RSP_NAK;
          end
        end
        CMD_RESET: begin
          rsp_nxt      = RSP_ACK;
          state_nxt    = ST_IDLE;
          flags_nxt    = 2'b00;
          words_nxt    = '0;
          xfer_rst_nxt = 1'b1;
          cmd_moves    = 1'b1;
          cmd_reset    = 1'b1;
        end
        default: rsp_nxt = RSP_NAK;
      endcase
    end

    // Capture wait: done beats timeout; a state-changing command beats both.
    if (state == ST_CAPTURING && !cmd_moves) begin
      if (capture_done) begin
        state_nxt = ST_READY;
      end else if (tcnt == TCNT_LAST) begin
        state_nxt    = ST_IDLE;
        flags_nxt[1] = 1'b1;
      end else begin
        tcnt_nxt = tcnt + 1'b1;
      end
    end

    // Word counting keeps going alongside commands, except a RESET which zeroes it.
    if (state == ST_READOUT && word_tick && !cmd_reset && words_sent != WORDS_FULL) begin
      words_nxt = words_sent + 1'b1;
      if (words_sent == WORDS_LAST && !cmd_moves) begin
        state_nxt = ST_DRAIN;
        dcnt_nxt  = '0;
      end
    end

    // Master released CS mid-frame: abandon everything but the response byte.
    if (cs_abort) begin
      state_nxt     = ST_IDLE;
      flags_nxt     = {error_flags[1], 1'b1};
      words_nxt     = words_sent;
      tcnt_nxt      = tcnt;
      dcnt_nxt      = dcnt;
      cap_start_nxt = 1'b0;
      xfer_rst_nxt  = 1'b0;
    end

    data_transfer_nxt = (state_nxt == ST_READOUT) || (state_nxt == ST_DRAIN);
  end

endmodule

// File: tb/tb_spi_readout_sequencer.sv
// Testbench for spi_readout_sequencer: directed scenarios followed by random
// command/event traffic. A reference model predicts the full output vector
// for every clock; a monitor pops and compares one prediction per edge.
module tb_spi_readout_sequencer;

  localparam int FW  = 4;
  localparam int DB  = 3;
  localparam int TO  = 16;
  localparam int WW  = 3;
  localparam int EW  = 19;

  localparam logic [7:0] C_NOP     = 8'h00;
  localparam logic [7:0] C_STATUS  = 8'h01;
  localparam logic [7:0] C_CAPTURE = 8'h02;
  localparam logic [7:0] C_START   = 8'h03;
  localparam logic [7:0] C_PADDING = 8'h04;
  localparam logic [7:0] C_STOP    = 8'h05;
  localparam logic [7:0] C_RESET   = 8'h06;
  localparam logic [7:0] ACK       = 8'hA5;
  localparam logic [7:0] NAK       = 8'h5A;

  // ---------------- clock / reset ----------------
  logic          sys_clk;
  logic          rst_n;
  logic [7:0]    command_byte;
  logic          command_valid;
  logic          cs_active;
  logic          capture_done;
  logic          word_tick;
  logic [7:0]    response_byte;
  logic          data_transfer;
  logic          capture_start;
  logic          transfer_reset;
  logic [WW-1:0] words_sent;
  logic [1:0]    error_flags;
  logic [2:0]    state_out;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  spi_readout_sequencer #(
    .FRAME_WORDS(FW), .WCNT_W(WW), .DRAIN_BYTES(DB), .CAPTURE_TIMEOUT(TO)
  ) dut (
    .sys_clk(sys_clk), .reset(rst_n),
    .command_byte(command_byte), .command_valid(command_valid),
    .cs_active(cs_active), .capture_done(capture_done), .word_tick(word_tick),
    .response_byte(response_byte), .data_transfer(data_transfer),
    .capture_start(capture_start), .transfer_reset(transfer_reset),
    .words_sent(words_sent), .error_flags(error_flags), .state_out(state_out)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit cs_level = 1'b1;
  bit rst_req  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // States as plain numbers: 0 idle, 1 capturing, 2 ready, 3 readout, 4 drain.
  int         m_state, m_words, m_tcnt, m_dcnt;
  logic [7:0] m_rsp;
  logic [1:0] m_flags;
  bit         m_cs_prev, m_cap, m_xrst, m_dt;

  task automatic model_step(input bit rst, input bit cv, input logic [7:0] cb,
                            input bit cs, input bit cd, input bit wt);
    int s;
    bit streaming, abort, took, rst_cmd;
    if (!rst) begin
      m_state = 0; m_words = 0; m_tcnt = 0; m_dcnt = 0; m_rsp = 8'h00;
      m_flags = 2'b00; m_cs_prev = 0; m_cap = 0; m_xrst = 0; m_dt = 0;
      return;
    end
    s         = m_state;
    streaming = (s == 3) || (s == 4);
    abort     = streaming && m_cs_prev && !cs;
    m_cs_prev = cs;
    m_cap     = 0;
    m_xrst    = 0;
    took      = 0;
    rst_cmd   = 0;
    // the response reflects the state and flags before anything this cycle
    if (cv) begin
      case (cb)
        C_NOP:     m_rsp = 8'h00;
        C_STATUS:  m_rsp = {m_flags, 3'b000, 3'(s)};
        C_CAPTURE: m_rsp = (s == 0 || s == 2) ? ACK : NAK;
        C_START:   m_rsp = (s == 2) ? ACK : NAK;
        C_PADDING: m_rsp = ACK;
        C_STOP:    m_rsp = streaming ? ACK : NAK;
        C_RESET:   m_rsp = ACK;
        default:   m_rsp = NAK;
      endcase
    end
    if (abort) begin
      m_state    = 0;
      m_flags[0] = 1'b1;
      m_dt       = 0;
      return;
    end
    if (cv) begin
      case (cb)
        C_CAPTURE: if (s == 0 || s == 2) begin
          m_state = 1; m_cap = 1; m_tcnt = 0; m_flags[1] = 1'b0; took = 1;
        end
        C_START: if (s == 2) begin
          m_state = 3; m_xrst = 1; m_words = 0; m_flags[0] = 1'b0; took = 1;
        end
        C_PADDING: if (s == 4) begin
          m_dcnt = m_dcnt + 1; took = 1;
          if (m_dcnt == DB) m_state = 0;
        end
        C_STOP: if (streaming) begin
          m_state = 0; took = 1;
        end
        C_RESET: begin
          m_state = 0; m_flags = 2'b00; m_words = 0; m_xrst = 1; took = 1; rst_cmd = 1;
        end
        default: ;
      endcase
    end
    if (s == 1 && !took) begin
      if (cd) m_state = 2;
      else if (m_tcnt == TO - 1) begin m_state = 0; m_flags[1] = 1'b1; end
      else m_tcnt = m_tcnt + 1;
    end
    if (s == 3 && wt && !rst_cmd && m_words < FW) begin
      m_words = m_words + 1;
      if (m_words == FW && !took) begin m_state = 4; m_dcnt = 0; end
    end
    m_dt = (m_state == 3) || (m_state == 4);
  endtask

  function automatic logic [EW-1:0] model_vec();
    return {m_rsp, 3'(m_state), m_dt, m_cap, m_xrst, WW'(m_words), m_flags};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit cv, input logic [7:0] cb, input bit cd, input bit wt);
    @(negedge sys_clk);
    rst_n         = rst_req;
    command_valid = cv;
    command_byte  = cb;
    cs_active     = cs_level;
    capture_done  = cd;
    word_tick     = wt;
    model_step(rst_req, cv, cb, cs_level, cd, wt);
    exp_q.push_back(model_vec());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0);
  endtask

  task automatic cmd(input logic [7:0] cb);
    cycle(1, cb, 0, 0);
  endtask

  task automatic post();
    @(posedge sys_clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("response_byte",  32'(response_byte),  32'(e[18:11]));
        check("state_out",      32'(state_out),      32'(e[10:8]));
        check("data_transfer",  32'(data_transfer),  32'(e[7]));
        check("capture_start",  32'(capture_start),  32'(e[6]));
        check("transfer_reset", 32'(transfer_reset), 32'(e[5]));
        check("words_sent",     32'(words_sent),     32'(e[4:2]));
        check("error_flags",    32'(error_flags),    32'(e[1:0]));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    logic [7:0] cb;
    rst_n = 1'b0; command_byte = 8'h00; command_valid = 1'b0;
    cs_active = 1'b1; capture_done = 1'b0; word_tick = 1'b0;

    // reset and first commands
    rst_req = 0; idle(3);
    post();
    check("reset_state", 32'(state_out), 0);
    check("reset_response", 32'(response_byte), 0);
    rst_req = 1; idle(2);
    cmd(C_STATUS); post();
    check("status_idle", 32'(response_byte), 32'h00);
    cmd(C_START); post();
    check("start_in_idle_nak", 32'(response_byte), 32'(NAK));
    check("start_in_idle_dt", 32'(data_transfer), 0);

    // capture, done 10 cycles later
    cmd(C_CAPTURE); post();
    check("capture_ack", 32'(response_byte), 32'(ACK));
    check("capture_start_pulse", 32'(capture_start), 1);
    idle(1); post();
    check("capture_start_one_cycle", 32'(capture_start), 0);
    idle(8);
    cycle(0, 8'h00, 1, 0); post();
    check("ready_state", 32'(state_out), 2);
    cmd(C_STATUS); post();
    check("status_ready", 32'(response_byte), 32'h02);

    // full readout and drain
    cmd(C_START); post();
    check("start_ack", 32'(response_byte), 32'(ACK));
    check("start_xfer_reset", 32'(transfer_reset), 1);
    check("start_dt", 32'(data_transfer), 1);
    for (int i = 0; i < FW; i++) cycle(0, 8'h00, 0, 1);
    post();
    check("frame_words", 32'(words_sent), 32'(FW));
    check("drain_state", 32'(state_out), 4);
    cmd(C_PADDING); cmd(C_PADDING); post();
    check("drain_still_dt", 32'(data_transfer), 1);
    cmd(C_PADDING); post();
    check("drain_done_state", 32'(state_out), 0);
    check("drain_done_dt", 32'(data_transfer), 0);

    // capture timeout
    cmd(C_CAPTURE); idle(15); post();
    check("timeout_not_yet", 32'(state_out), 1);
    idle(1); post();
    check("timeout_idle", 32'(state_out), 0);
    cmd(C_STATUS); post();
    check("status_timeout", 32'(response_byte), 32'h80);

    // CS abort mid-readout
    cmd(C_CAPTURE); cycle(0, 8'h00, 1, 0); cmd(C_START);
    cycle(0, 8'h00, 0, 1); cycle(0, 8'h00, 0, 1); post();
    check("abort_words_before", 32'(words_sent), 2);
    cs_level = 0; idle(1); post();
    check("abort_state", 32'(state_out), 0);
    check("abort_dt", 32'(data_transfer), 0);
    cmd(C_STATUS); post();
    check("status_abort", 32'(response_byte), 32'h40);
    cs_level = 1; cmd(C_RESET); post();
    check("reset_cmd_flags", 32'(error_flags), 0);

    // STOP_READOUT colliding with the final tick, unknown opcodes
    cmd(C_CAPTURE); cycle(0, 8'h00, 1, 0); cmd(C_START);
    for (int i = 0; i < FW - 1; i++) cycle(0, 8'h00, 0, 1);
    cycle(1, C_STOP, 0, 1); post();
    check("stop_vs_tick_state", 32'(state_out), 0);
    check("stop_vs_tick_rsp", 32'(response_byte), 32'(ACK));
    cmd(8'hFF); post();
    check("unknown_idle_nak", 32'(response_byte), 32'(NAK));
    cmd(C_CAPTURE); cycle(0, 8'h00, 1, 0); cmd(C_START); cmd(8'hFF); post();
    check("unknown_readout_nak", 32'(response_byte), 32'(NAK));
    check("unknown_readout_state", 32'(state_out), 3);
    cmd(C_STOP);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (cs_level) cs_level = ($urandom_range(0, 99) >= 2);
      else          cs_level = ($urandom_range(0, 99) < 30);
      rst_req = ($urandom_range(0, 999) >= 3);
      r = $urandom_range(0, 15);
      case (r)
        0:           cb = C_NOP;
        1, 2:        cb = C_STATUS;
        3, 4:        cb = C_CAPTURE;
        5, 6, 7:     cb = C_START;
        8, 9, 10:    cb = C_PADDING;
        11:          cb = C_STOP;
        12:          cb = C_RESET;
        13:          cb = 8'($urandom_range(0, 255));
        default:     cb = C_PADDING;
      endcase
      cycle($urandom_range(0, 99) < 35, cb, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 40);
    end
    rst_req = 1; cs_level = 1; idle(2);

    // asynchronous reset while streaming
    cmd(C_RESET); cmd(C_CAPTURE); cycle(0, 8'h00, 1, 0); cmd(C_START); post();
    check("pre_async_dt", 32'(data_transfer), 1);
    @(negedge sys_clk); #2;
    rst_n = 1'b0; #1;
    check("async_reset_dt", 32'(data_transfer), 0);
    check("async_reset_state", 32'(state_out), 0);
    rst_req = 0; idle(2);
    rst_req = 1; idle(2); post();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
